// File: rtl/servo_adc_pwm_ctrl.sv
// rtl/servo_adc_pwm_ctrl.sv - serial ADC frame capture driving a slew-limited servo PWM
module servo_adc_pwm_ctrl #(
    parameter int SCLK_DIV   = 4,
    parameter int FRAME_BITS = 16,
    parameter int ADC_BITS   = 12,
    parameter int CMD_BITS   = 8,
    parameter int PERIOD     = 2000000,
    parameter int PULSE_MIN  = 100000,
    parameter int PULSE_STEP = 392,
    parameter int SLEW_MAX   = 0
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                sdata,
    input  logic                hold,
    output logic                cs,
    output logic                sclk,
    output logic [ADC_BITS-1:0] sample,
    output logic                sample_valid,
    output logic [CMD_BITS-1:0] cmd,
    output logic                pwm_out
);
    localparam int CNT_W = $clog2(PERIOD);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int CW1   = CMD_BITS + 1;
    localparam int PXW   = CMD_BITS + 32;
    localparam logic [CW1-1:0] SLEW = CW1'(SLEW_MAX);

    typedef enum logic [1:0] {IDLE, CONV, DONE} adc_state_t;

    adc_state_t          state, state_next;
    logic [CNT_W-1:0]    per_cnt;
    logic                period_start;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [ADC_BITS-1:0] shift;
    logic                tick, rise, last_rise;
    logic [CMD_BITS-1:0] target, cmd_next, cmd_active, cmd_sel;
    logic [CW1-1:0]      mag;
    logic                up;
    logic [PXW-1:0]      pulse;

    assign period_start = (per_cnt == '0);

    always_ff @(posedge Clk) begin
        if (!Rst)
            per_cnt <= '0;
        else if (per_cnt == CNT_W'(PERIOD - 1))
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + 1'b1;
    end

    assign tick      = (state == CONV) && (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign rise      = tick && !sclk;
    assign last_rise = rise && (bit_cnt == BIT_W'(FRAME_BITS - 1));

    always_ff @(posedge Clk) begin
        if (!Rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (period_start) state_next = CONV;
            CONV:    if (last_rise) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Only the trailing ADC_BITS of the frame survive the shift; leading pad bits fall off.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cs           <= 1'b1;
            sclk         <= 1'b1;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (period_start) begin
                        cs      <= 1'b0;
                        sclk    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONV: begin
                    if (tick) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (rise) begin
                            shift   <= {shift[ADC_BITS-2:0], sdata};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (last_rise)
                        cs <= 1'b1;
                end
                DONE: begin
                    sample       <= shift;
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Difference is carried in CMD_BITS+1 bits so the step never overshoots or wraps.
    always_comb begin
        target   = sample[ADC_BITS-1 -: CMD_BITS];
        up       = (target > cmd);
        mag      = up ? ({1'b0, target} - {1'b0, cmd}) : ({1'b0, cmd} - {1'b0, target});
        cmd_next = target;
        if (SLEW_MAX != 0 && mag > SLEW)
            cmd_next = up ? (cmd + SLEW[CMD_BITS-1:0]) : (cmd - SLEW[CMD_BITS-1:0]);
    end

    always_ff @(posedge Clk) begin
        if (!Rst)
            cmd <= '0;
        else if (sample_valid && !hold)
            cmd <= cmd_next;
    end

    // At period start the freshly latched command already sets this period's width.
    assign cmd_sel = period_start ? cmd : cmd_active;
    assign pulse   = PXW'(PULSE_MIN) + PXW'(cmd_sel) * PXW'(PULSE_STEP);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cmd_active <= '0;
            pwm_out    <= 1'b0;
        end else begin
            if (period_start)
                cmd_active <= cmd;
            pwm_out <= (PXW'(per_cnt) < pulse);
        end
    end
endmodule

// File: tb/tb_servo_adc_pwm_ctrl.sv
// tb/tb_servo_adc_pwm_ctrl.sv - directed bench for servo_adc_pwm_ctrl
module tb_servo_adc_pwm_ctrl;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        sdata = 1'b0;
    logic        hold;
    logic        cs, sclk, sample_valid, pwm_out;
    logic [11:0] sample;
    logic [7:0]  cmd;
    logic        s_cs, s_sclk, s_sample_valid, s_pwm_out;
    logic [11:0] s_sample;
    logic [7:0]  s_cmd;

    int errors = 0;
    int checks = 0;

    logic [15:0] frame = 16'h0000;
    int          adc_idx = 15;
    logic        prev_sclk, prev_pwm;
    int          hi, cslo, rises, svs, pedges;

    servo_adc_pwm_ctrl #(
        .SCLK_DIV(2), .FRAME_BITS(16), .ADC_BITS(12), .CMD_BITS(8),
        .PERIOD(400), .PULSE_MIN(40), .PULSE_STEP(1), .SLEW_MAX(0)
    ) dut (
        .Clk(Clk), .Rst(Rst), .sdata(sdata), .hold(hold),
        .cs(cs), .sclk(sclk), .sample(sample), .sample_valid(sample_valid),
        .cmd(cmd), .pwm_out(pwm_out)
    );

    servo_adc_pwm_ctrl #(
        .SCLK_DIV(2), .FRAME_BITS(16), .ADC_BITS(12), .CMD_BITS(8),
        .PERIOD(400), .PULSE_MIN(40), .PULSE_STEP(1), .SLEW_MAX(16)
    ) dut_s (
        .Clk(Clk), .Rst(Rst), .sdata(sdata), .hold(hold),
        .cs(s_cs), .sclk(s_sclk), .sample(s_sample), .sample_valid(s_sample_valid),
        .cmd(s_cmd), .pwm_out(s_pwm_out)
    );

    always #5 Clk = ~Clk;

    // ADC model: new bit on each falling sclk, MSB first, restarted by cs falling.
    always @(negedge cs) adc_idx = 15;
    always @(negedge sclk) begin
        if (!cs && adc_idx >= 0) begin
            sdata   = frame[adc_idx];
            adc_idx = adc_idx - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_period(input logic [15:0] frm);
        frame  = frm;
        hi     = 0;
        cslo   = 0;
        rises  = 0;
        svs    = 0;
        pedges = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (pwm_out) hi++;
            if (!cs) cslo++;
            if (sclk && !prev_sclk) rises++;
            if (pwm_out && !prev_pwm) pedges++;
            if (sample_valid) svs++;
            prev_sclk = sclk;
            prev_pwm  = pwm_out;
        end
    endtask

    task automatic release_reset();
        Rst       = 1'b1;
        prev_sclk = 1'b1;
        prev_pwm  = 1'b0;
    endtask

    initial begin
        Rst  = 1'b0;
        hold = 1'b0;
        repeat (5) @(negedge Clk);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_sv", 32'(sample_valid), 32'd0);
        release_reset();

        run_period(16'h0AB5);
        chk("p1_pulse", 32'(hi), 32'd40);
        chk("p1_cs_low", 32'(cslo), 32'd64);
        chk("p1_sclk_rises", 32'(rises), 32'd16);
        chk("p1_sv_count", 32'(svs), 32'd1);
        chk("p1_pwm_edges", 32'(pedges), 32'd1);
        chk("p1_sample", 32'(sample), 32'h0AB5);
        chk("p1_cmd", 32'(cmd), 32'h00AB);
        chk("p1_slew_cmd", 32'(s_cmd), 32'd16);

        run_period(16'h0AB5);
        chk("p2_pulse", 32'(hi), 32'd211);
        chk("p2_cmd", 32'(cmd), 32'h00AB);
        chk("p2_slew_cmd", 32'(s_cmd), 32'd32);

        hold = 1'b1;
        run_period(16'h0800);
        chk("p3_pulse", 32'(hi), 32'd211);
        chk("p3_sample", 32'(sample), 32'h0800);
        chk("p3_sv_count", 32'(svs), 32'd1);
        chk("p3_cmd_held", 32'(cmd), 32'h00AB);
        chk("p3_slew_held", 32'(s_cmd), 32'd32);

        run_period(16'h0800);
        chk("p4_pulse", 32'(hi), 32'd211);
        chk("p4_cmd_held", 32'(cmd), 32'h00AB);

        hold = 1'b0;
        run_period(16'h0800);
        chk("p5_pulse", 32'(hi), 32'd211);
        chk("p5_cmd", 32'(cmd), 32'h0080);
        chk("p5_slew_cmd", 32'(s_cmd), 32'd48);
        chk("p5_cs_low", 32'(cslo), 32'd64);

        run_period(16'h0FFF);
        chk("p6_pulse", 32'(hi), 32'd168);
        chk("p6_cmd", 32'(cmd), 32'h00FF);
        chk("p6_slew_cmd", 32'(s_cmd), 32'd64);

        run_period(16'h0000);
        chk("p7_pulse_max", 32'(hi), 32'd295);
        chk("p7_pwm_edges", 32'(pedges), 32'd1);
        chk("p7_cmd", 32'(cmd), 32'd0);
        chk("p7_slew_cmd", 32'(s_cmd), 32'd48);

        run_period(16'h0000);
        chk("p8_pulse_min", 32'(hi), 32'd40);
        chk("p8_pwm_edges", 32'(pedges), 32'd1);

        frame = 16'h0555;
        repeat (30) @(negedge Clk);
        chk("mid_cs_low", 32'(cs), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        chk("mid_rst_cs", 32'(cs), 32'd1);
        chk("mid_rst_sclk", 32'(sclk), 32'd1);
        chk("mid_rst_sv", 32'(sample_valid), 32'd0);
        chk("mid_rst_sample", 32'(sample), 32'd0);
        chk("mid_rst_pwm", 32'(pwm_out), 32'd0);
        repeat (2) @(negedge Clk);
        chk("mid_rst_sv2", 32'(sample_valid), 32'd0);
        release_reset();

        run_period(16'h0123);
        chk("p9_pulse", 32'(hi), 32'd40);
        chk("p9_cs_low", 32'(cslo), 32'd64);
        chk("p9_sample", 32'(sample), 32'h0123);
        chk("p9_cmd", 32'(cmd), 32'h0012);
        chk("p9_slew_cmd", 32'(s_cmd), 32'd16);

        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        release_reset();
        for (int i = 0; i < 16; i++) begin
            run_period(16'h0FF0);
            chk($sformatf("slew_up_%0d", i), 32'(s_cmd), (i == 15) ? 32'd255 : 32'(16 * (i + 1)));
        end
        for (int i = 0; i < 16; i++) begin
            run_period(16'h0000);
            chk($sformatf("slew_dn_%0d", i), 32'(s_cmd), (i == 15) ? 32'd0 : 32'(255 - 16 * (i + 1)));
        end
        chk("slew_unl_cmd", 32'(cmd), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/servo_adc_pwm_ctrl.md
Name: servo_adc_pwm_ctrl

Overview:
Parametrised successor to the single-channel ADC-to-PWM servo path. It reads a serial ADC frame once per servo period and extracts a command from the sample MSBs. The command passes through an optional slew-rate limit and a hold mode, then drives a servo PWM whose pulse width is PULSE_MIN + cmd*PULSE_STEP. It sits directly between the ADC pins (sdata/cs/sclk) and the servo output pin.

Parameters:
SCLK_DIV, 4: Clk cycles per sclk half-period (>=1).
FRAME_BITS, 16: sclk bits per ADC frame.
ADC_BITS, 12: data bits, the last ADC_BITS bits of the frame (<=FRAME_BITS).
CMD_BITS, 8: command width, taken from sample MSBs (<=ADC_BITS).
PERIOD, 2000000: PWM period in Clk cycles. Must exceed 2*SCLK_DIV*FRAME_BITS+2.
PULSE_MIN, 100000: pulse width in cycles at cmd=0.
PULSE_STEP, 392: extra pulse cycles per cmd LSB. PULSE_MIN+(2^CMD_BITS-1)*PULSE_STEP must be < PERIOD.
SLEW_MAX, 0: maximum cmd change per accepted sample. 0 means unlimited.

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  synchronous, active-low reset
sdata  in  1  ADC serial data, MSB first
hold  in  1  1 = freeze cmd; samples are still captured
cs  out  1  ADC chip select, active low
sclk  out  1  ADC serial clock, idles high
sample  out  ADC_BITS  last captured ADC value
sample_valid  out  1  one-cycle pulse when sample updates
cmd  out  CMD_BITS  current slew-limited command
pwm_out  out  1  servo PWM output

Behaviour:
- Clocking and reset: all state is on Clk rising edges. Rst is sampled synchronously, active low.
- Reset values: cs=1, sclk=1, sample=0, sample_valid=0, cmd=0, pwm_out=0; period counter=0, latched cmd_active=0, ADC FSM=IDLE.
- Period counter: counts 0..PERIOD-1 and wraps. Counter==0 marks period start.
- ADC FSM states are IDLE, CONV, DONE.
- IDLE -> CONV on period start. cs drops low on the next cycle.
- In CONV, sclk toggles every SCLK_DIV cycles, first toggle high->low.
- sdata is sampled on the Clk cycle in which sclk rises, and shifted in MSB first.
- After the FRAME_BITS-th rising edge, CONV -> DONE.
- cs is low for exactly 2*SCLK_DIV*FRAME_BITS cycles. cs returns high and sclk stays high on entry to DONE.
- DONE lasts 1 cycle: sample <= low ADC_BITS of the shift register, sample_valid=1, then -> IDLE.
- Command update runs on the sample_valid cycle; cmd is registered 1 cycle later.
  - target = sample[ADC_BITS-1 -: CMD_BITS].
  - If hold=1, cmd is unchanged.
  - Else if SLEW_MAX=0 or |target-cmd|<=SLEW_MAX, cmd <= target.
  - Else cmd moves toward target by exactly SLEW_MAX.
- Slew arithmetic is unsigned with the difference in CMD_BITS+1 bits. cmd never overshoots target and never wraps.
- PWM output:
  - cmd_active <= cmd at each period start, so a sample taken in period k takes effect in period k+1.
  - pulse = PULSE_MIN + cmd_active*PULSE_STEP, computed at full width without truncation.
  - pwm_out is registered: high for exactly pulse cycles starting the cycle after period start, otherwise low.
  - A change of cmd mid-period never alters the current pulse.
- Rst low mid-conversion: the frame is discarded, no sample_valid, all outputs take reset values on that edge. After release, the counter restarts at 0, a fresh conversion begins, and the first pulse is PULSE_MIN.
- hold toggling never restarts the ADC or PWM timing.

Test Plan:
All scenarios use SCLK_DIV=2, FRAME_BITS=16, ADC_BITS=12, CMD_BITS=8, PERIOD=400, PULSE_MIN=40, PULSE_STEP=1.
1. Reset: Rst=0 for 5 cycles, then 1 -> during reset cs=1, sclk=1, pwm_out=0, cmd=0. First period gives pwm_out high exactly 40 cycles and cs low exactly 64 cycles with 16 sclk rising edges.
2. Capture: ADC model drives frame 0x0AB5 -> sample=0xAB5, one sample_valid pulse, cmd=0xAB. The next period's pulse is 211 cycles; the current period's pulse stays 40.
3. Slew: SLEW_MAX=16, frame 0x0FF0 every period from cmd=0 -> cmd=16,32,...,240,255 (16 samples, final step 15). Then frame 0x0000 -> 239,223,... down to 0.
4. Hold: cmd=0xAB, hold=1, frame 0x0800 -> sample=0x800, sample_valid pulses, cmd stays 0xAB, pulse stays 211. After hold=0, the next sample sets cmd=0x80.
5. Reset mid-frame: Rst=0 on cycle 30 of CONV -> cs=1 and sclk=1 on that edge, no sample_valid, sample=0. After release, the next frame 0x0123 yields sample=0x123.
6. Extremes: frame 0x0FFF -> cmd=255, pulse=295. Frame 0x0000 -> pulse=40. No glitch on pwm_out across the period boundary.
